dram_burst_initiator: RTL and testbench
=======================================

DRAM_BURST_INITIATOR -- requirements
Module: dram_burst_initiator

Interface
REQ-001 Parameters (name, default, meaning), one per line: DATA, 32, data word width.
REQ-002 ADDR, 32, word-address width.
REQ-003 LEN, 8, burst-length field width.
REQ-004 Ports (name, direction, width, meaning) SHALL be as listed here and in REQ-005 to REQ-012: clk, input, 1, the only clock, rising edge.
REQ-005 reset, input, 1, synchronous, active-high.
REQ-006 req_valid / req_ready, input / output, 1 each, burst request handshake.
REQ-007 req_wr, input, 1, 1 = write burst, 0 = read burst.
REQ-008 req_addr, input, ADDR, start word address; req_len, input, LEN, beats minus 1.
REQ-009 wdata_valid / wdata_ready / wdata, input / output / input, 1 / 1 / DATA, write data stream.
REQ-010 rdata_valid / rdata_ready / rdata / rdata_last, output / input / output / output, 1 / 1 / DATA / 1, read data stream.
REQ-011 done, output, 1, single-cycle burst-complete pulse.
REQ-012 mem_wr, mem_addr, mem_din outputs (1 / ADDR / DATA) and mem_dout input (DATA) SHALL drive a single-port memory: write on mem_wr at the rising edge; registered read, so mem_dout is valid one cycle after the address is presented with mem_wr=0.

Function
REQ-013 FSM states SHALL be IDLE, WRITE, READ and RDRAIN.
REQ-014 req_ready SHALL be 1 only in IDLE.
REQ-015 When req_valid && req_ready: latch addr, remaining = req_len + 1 and direction; go to WRITE or READ.
REQ-016 In WRITE: wdata_ready = 1. On each wdata handshake, in the same cycle: mem_wr = 1, mem_addr = current address, mem_din = wdata. Then address +1 and remaining -1.
REQ-017 mem_wr SHALL be 0 in every cycle without a WRITE-state wdata handshake.
REQ-018 Final write beat: the next cycle is IDLE with done = 1 for exactly one cycle.
REQ-019 Read beats SHALL use a 2-entry in-order FIFO and a single inflight flag.
REQ-020 In READ, a read SHALL be issued (mem_wr = 0, mem_addr = current address; address +1, remaining -1; inflight set for the next cycle) only when FIFO occupancy + inflight - pop_this_cycle < 2.
REQ-021 Each inflight cycle SHALL push mem_dout into the FIFO.
REQ-022 Sustained throughput with rdata_ready held high SHALL be 1 beat per cycle after a 1-cycle initial latency.
REQ-023 rdata_valid SHALL equal FIFO non-empty, and rdata SHALL be the FIFO head.
REQ-024 rdata_last SHALL be 1 on the head entry that is the final beat of the burst.
REQ-025 rdata and rdata_last SHALL stay stable while rdata_valid && !rdata_ready.
REQ-026 After the final read is issued, the FSM SHALL enter RDRAIN.
REQ-027 In RDRAIN, on the rdata_last handshake: go to IDLE and pulse done = 1 for one cycle, co-cycle with entering IDLE.
REQ-028 Address increment SHALL wrap modulo 2^ADDR; e.g. 0xFFFFFFFF is followed by 0x00000000.
REQ-029 req_len = 0 SHALL mean a 1-beat burst; req_len = 2^LEN - 1 SHALL mean 2^LEN beats.
REQ-030 Stalls: a missing wdata_valid, or a deasserted rdata_ready, SHALL only stall the burst; no beat is lost or duplicated.
REQ-031 A request SHALL never be accepted while a burst is active or the read FIFO is non-empty.
REQ-032 In IDLE, mem_addr SHALL hold the last driven value.

Reset
REQ-033 While reset is high at a rising edge: state IDLE, FIFO flushed, inflight cleared, remaining 0.
REQ-034 Output values during and after that edge: req_ready = 1 after the reset edge; wdata_ready, rdata_valid, rdata_last, done and mem_wr = 0; mem_addr, mem_din and rdata = 0.
REQ-035 Reset mid-burst SHALL abort the burst with no done pulse.
REQ-036 Memory data returning in the cycle after reset SHALL be discarded.

Verification
REQ-037 Write 4 beats at 0x10: data A0..A3 with wdata_valid always high -> mem_wr high 4 consecutive cycles at 0x10..0x13; done pulses once the following cycle.
REQ-038 Read 4 beats at 0x10 with rdata_ready = 1 (memory preloaded A0..A3) -> rdata A0..A3 on 4 consecutive cycles starting 2 cycles after acceptance; rdata_last only on A3; then done.
REQ-039 Same read with rdata_ready toggling 1,0,0,1,... -> exact in-order A0..A3; FIFO never overflows; never more than 2 reads outstanding beyond pops.
REQ-040 Write of 2 beats at 0xFFFFFFFF -> mem_addr 0xFFFFFFFF then 0x00000000.
REQ-041 req_len = 0 read -> single beat with rdata_last = 1; req_ready low until that beat is consumed.
REQ-042 Reset asserted on the 2nd beat of an 8-beat read -> next cycle rdata_valid = 0, req_ready = 1, no done, no stale data later.

Source files
------------

// File: rtl/dram_burst_initiator.sv
// Burst initiator: accepts one read or write burst request at a time and
// sequences it word by word against a single-port, registered-read memory.
// Read data is buffered in a two-entry in-order FIFO so that back-pressure
// on the read stream never drops or duplicates a beat.
module dram_burst_initiator #(
    parameter int DATA = 32,
    parameter int ADDR = 32,
    parameter int LEN  = 8
) (
    input  logic            clk,
    input  logic            reset,
    // burst request
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [ADDR-1:0] req_addr,
    input  logic [LEN-1:0]  req_len,
    // write data stream
    input  logic            wdata_valid,
    output logic            wdata_ready,
    input  logic [DATA-1:0] wdata,
    // read data stream
    output logic            rdata_valid,
    input  logic            rdata_ready,
    output logic [DATA-1:0] rdata,
    output logic            rdata_last,
    // completion
    output logic            done,
    // memory port
    output logic            mem_wr,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_din,
    input  logic [DATA-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RDRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [ADDR-1:0] last_addr_q, last_addr_d;
    logic [LEN:0]    rem_q, rem_d;
    logic            inflight_q, inflight_d;
    logic            infl_last_q, infl_last_d;
    logic            done_q, done_d;

    logic [DATA-1:0] fifo_data_q [2];
    logic            fifo_last_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      count_q;

    logic            push, pop, head_last, can_issue;
    logic [2:0]      occupancy;

    assign push        = inflight_q;
    assign rdata_valid = (count_q != 2'd0);
    assign pop         = rdata_valid && rdata_ready;
    assign head_last   = fifo_last_q[rd_ptr_q];
    assign rdata       = rdata_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign rdata_last  = rdata_valid && head_last;
    assign done        = done_q;

    // A new read may be issued only if its data is guaranteed a FIFO slot
    // when it returns, counting the beat already in flight and any pop now.
    assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
    assign can_issue   = (occupancy - {2'b00, pop}) < 3'd2;

    // Next-state, memory-port and handshake decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        rem_d       = rem_q;
        inflight_d  = 1'b0;
        infl_last_d = 1'b0;
        done_d      = 1'b0;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = last_addr_q;
        mem_din     = '0;
        case (state_q)
            IDLE: begin
                req_ready = (count_q == 2'd0) && !inflight_q;
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    rem_d   = {1'b0, req_len} + {{LEN{1'b0}}, 1'b1};
                    state_d = req_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                mem_addr    = addr_q;
                last_addr_d = addr_q;
                if (wdata_valid) begin
                    mem_wr  = 1'b1;
                    mem_din = wdata;
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == {{LEN{1'b0}}, 1'b1}) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                mem_addr    = addr_q;
                last_addr_d = addr_q;
                if (can_issue) begin
                    addr_d      = addr_q + 1'b1;
                    rem_d       = rem_q - 1'b1;
                    inflight_d  = 1'b1;
                    infl_last_d = (rem_q == {{LEN{1'b0}}, 1'b1});
                    if (rem_q == {{LEN{1'b0}}, 1'b1}) begin
                        state_d = RDRAIN;
                    end
                end
            end
            RDRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            rem_q       <= rem_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

    // Read-data FIFO: captures memory output one cycle after each issued read
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_dout;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_dram_burst_initiator.sv
// Directed bench for dram_burst_initiator with a small behavioural
// single-port memory (registered read, 256 words indexed by address[7:0]).
module tb_dram_burst_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready, rdata_last;
    logic [31:0] rdata;
    logic        done;
    logic        mem_wr;
    logic [31:0] mem_addr, mem_din, mem_dout;

    int vec  = 0;
    int errs = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    dram_burst_initiator #(.DATA(32), .ADDR(32), .LEN(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .rdata(rdata), .rdata_last(rdata_last),
        .done(done),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[7:0]] <= mem_din;
        mem_dout <= mem[mem_addr[7:0]];
    end

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        vec++; if ({wdata_ready, rdata_valid, rdata_last, done, mem_wr} !== 5'b0) begin
            errs++; $display("FAIL reset_flags got %b exp 00000", {wdata_ready, rdata_valid, rdata_last, done, mem_wr}); end
        vec++; if ({mem_addr, mem_din, rdata} !== 96'h0) begin
            errs++; $display("FAIL reset_buses got %h exp 0", {mem_addr, mem_din, rdata}); end
        step();
    endtask

    task automatic test_write4();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h10; req_len = 8'd3;
        @(negedge clk);
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL wr4_accept got %b exp 1", req_ready); end
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdata_valid = 1'b1; wdata = 32'hA0 + i;
            @(negedge clk);
            vec++; if ({mem_wr, done} !== 2'b10) begin errs++; $display("FAIL wr4_memwr beat %0d got %b exp 10", i, {mem_wr, done}); end
            vec++; if (mem_addr !== 32'h10 + i) begin errs++; $display("FAIL wr4_addr beat %0d got %h exp %h", i, mem_addr, 32'h10 + i); end
            vec++; if (mem_din !== 32'hA0 + i) begin errs++; $display("FAIL wr4_din beat %0d got %h exp %h", i, mem_din, 32'hA0 + i); end
            step();
        end
        wdata_valid = 1'b0;
        @(negedge clk);
        vec++; if ({done, mem_wr, req_ready} !== 3'b101) begin errs++; $display("FAIL wr4_done got %b exp 101", {done, mem_wr, req_ready}); end
        vec++; if (mem_addr !== 32'h13) begin errs++; $display("FAIL wr4_idle_addr got %h exp 00000013", mem_addr); end
        step();
        @(negedge clk);
        vec++; if (done !== 1'b0) begin errs++; $display("FAIL wr4_done_once got %b exp 0", done); end
        step();
    endtask

    task automatic test_read4();
        rdata_ready = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_len = 8'd3;
        @(negedge clk);
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rd4_accept got %b exp 1", req_ready); end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        vec++; if ({mem_wr, mem_addr} !== {1'b0, 32'h10}) begin errs++; $display("FAIL rd4_issue got %b/%h exp 0/00000010", mem_wr, mem_addr); end
        vec++; if ({rdata_valid, req_ready} !== 2'b00) begin errs++; $display("FAIL rd4_lat1 got %b exp 00", {rdata_valid, req_ready}); end
        step();
        @(negedge clk);
        vec++; if (rdata_valid !== 1'b0) begin errs++; $display("FAIL rd4_lat2 got %b exp 0", rdata_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            vec++; if ({rdata_valid, rdata_last, done} !== {1'b1, (i == 3), 1'b0}) begin
                errs++; $display("FAIL rd4_flags beat %0d got %b exp %b", i, {rdata_valid, rdata_last, done}, {1'b1, (i == 3), 1'b0}); end
            vec++; if (rdata !== 32'hA0 + i) begin errs++; $display("FAIL rd4_data beat %0d got %h exp %h", i, rdata, 32'hA0 + i); end
        end
        step();
        @(negedge clk);
        vec++; if ({done, rdata_valid, req_ready} !== 3'b101) begin errs++; $display("FAIL rd4_done got %b exp 101", {done, rdata_valid, req_ready}); end
        step();
    endtask

    task automatic test_read_backpressure();
        logic [3:0]  pat = 4'b1001;
        int          got = 0;
        bit          seen_done = 0;
        bit          prev_stall = 0;
        logic [32:0] prev = '0;
        rdata_ready = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_len = 8'd3;
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            rdata_ready = pat[c % 4];
            @(negedge clk);
            if (done) begin
                seen_done = 1;
                break;
            end
            if (rdata_valid) begin
                if (prev_stall) begin
                    vec++; if ({rdata_last, rdata} !== prev) begin errs++; $display("FAIL bp_stable got %h exp %h", {rdata_last, rdata}, prev); end
                end
                if (rdata_ready) begin
                    vec++; if ({rdata_last, rdata} !== {(got == 3), 32'hA0 + got}) begin
                        errs++; $display("FAIL bp_beat %0d got %h exp %h", got, {rdata_last, rdata}, {(got == 3), 32'hA0 + got}); end
                    got++;
                end
            end
            prev_stall = rdata_valid && !rdata_ready;
            prev = {rdata_last, rdata};
            step();
        end
        vec++; if (!seen_done || got != 4) begin errs++; $display("FAIL bp_complete got done=%0d beats=%0d exp done=1 beats=4", seen_done, got); end
        rdata_ready = 1'b1;
        step();
    endtask

    task automatic test_wrap_write();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'hFFFF_FFFF; req_len = 8'd1;
        step();
        req_valid = 1'b0;
        wdata_valid = 1'b1; wdata = 32'hB0;
        @(negedge clk);
        vec++; if ({mem_wr, mem_addr} !== {1'b1, 32'hFFFF_FFFF}) begin errs++; $display("FAIL wrap_beat0 got %b/%h exp 1/ffffffff", mem_wr, mem_addr); end
        step();
        wdata = 32'hB1;
        @(negedge clk);
        vec++; if ({mem_wr, mem_addr} !== {1'b1, 32'h0}) begin errs++; $display("FAIL wrap_beat1 got %b/%h exp 1/00000000", mem_wr, mem_addr); end
        step();
        wdata_valid = 1'b0;
        @(negedge clk);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL wrap_done got %b exp 1", done); end
        step();
    endtask

    task automatic test_single_beat_read();
        bit seen = 0;
        rdata_ready = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'hFFFF_FFFF; req_len = 8'd0;
        step();
        req_valid = 1'b1;  // keep requesting: must not be accepted until drained
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rdata_valid) begin seen = 1; break; end
            step();
        end
        vec++; if (!seen) begin errs++; $display("FAIL len0_timeout got valid=0 exp valid=1"); end
        for (int c = 0; c < 3; c++) begin
            vec++; if ({rdata_last, rdata, req_ready} !== {1'b1, 32'hB0, 1'b0}) begin
                errs++; $display("FAIL len0_hold cyc %0d got %h exp %h", c, {rdata_last, rdata, req_ready}, {1'b1, 32'hB0, 1'b0}); end
            step();
            @(negedge clk);
        end
        req_valid = 1'b0;
        rdata_ready = 1'b1;
        step();
        @(negedge clk);
        vec++; if ({done, rdata_valid, req_ready} !== 3'b101) begin errs++; $display("FAIL len0_done got %b exp 101", {done, rdata_valid, req_ready}); end
        step();
    endtask

    task automatic test_reset_mid_read();
        rdata_ready = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_len = 8'd7;
        step();
        req_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        vec++; if ({rdata_valid, rdata} !== {1'b1, 32'hA0}) begin errs++; $display("FAIL rst_first_beat got %h exp 1000000a0", {rdata_valid, rdata}); end
        step();
        reset = 1'b1;
        @(negedge clk);
        vec++; if ({rdata_valid, rdata} !== {1'b1, 32'hA1}) begin errs++; $display("FAIL rst_second_beat got %h exp 1000000a1", {rdata_valid, rdata}); end
        step();
        reset = 1'b0;
        @(negedge clk);
        vec++; if ({rdata_valid, req_ready, done, rdata} !== {3'b010, 32'h0}) begin
            errs++; $display("FAIL rst_abort got %h exp %h", {rdata_valid, req_ready, done, rdata}, {3'b010, 32'h0}); end
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            vec++; if ({rdata_valid, done, mem_wr, req_ready} !== 4'b0001) begin
                errs++; $display("FAIL rst_quiet cyc %0d got %b exp 0001", c, {rdata_valid, done, mem_wr, req_ready}); end
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        #1;
        test_reset();
        test_write4();
        test_read4();
        test_read_backpressure();
        test_wrap_write();
        test_single_beat_read();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
